// File: rtl/alu_exec_mc.sv
// alu_exec_mc: multi-cycle EX-stage execute unit.
// Logic ops, add and compare finish in one cycle. Shifts walk one bit
// position per cycle through a working register, so no barrel shifter
// is needed. Valid/ready handshakes are used on both sides.
module alu_exec_mc #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t               state, state_nxt;
   logic [1:0]           shk_q;    // shift kind: 00 sll, 01 srl, 10 sra
   logic [XLEN-1:0]      work_q;   // shift working register, then the result
   logic [SHAMT_W-1:0]   cnt_q;    // remaining shift steps
   logic                 ill_q;
   logic                 accept;
   logic                 is_shift;
   logic [SHAMT_W-1:0]   shamt;

   // Single-cycle operations; shift codes are handled by the iterative path.
   function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] c,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
      logic [XLEN-1:0] sum;
      sum = a + b;
      case (c)
         4'b0000: alu_fn = sum;
         4'b0001: alu_fn = b;
         4'b0011: alu_fn = {sum[XLEN-1:1], 1'b0};
         4'b0100: alu_fn = {{(XLEN-1){1'b0}}, (a < b)};
         4'b0101: alu_fn = a ^ b;
         4'b0110: alu_fn = a | b;
         4'b0111: alu_fn = a & b;
         default: alu_fn = '0;
      endcase
   endfunction

   // Unassigned opcodes: 0010 and 1011-1111.
   function automatic logic is_illegal(input logic [3:0] c);
      is_illegal = (c == 4'b0010) || (c > 4'b1010);
   endfunction

   // One-bit shift step; sra replicates the sign bit.
   function automatic logic [XLEN-1:0] shift1(input logic [1:0] k,
                                              input logic [XLEN-1:0] v);
      logic signed [XLEN-1:0] sv;
      sv = v;
      case (k)
         2'b00:   shift1 = {v[XLEN-2:0], 1'b0};
         2'b01:   shift1 = {1'b0, v[XLEN-1:1]};
         default: shift1 = sv >>> 1;
      endcase
   endfunction

   assign shamt    = src_b[SHAMT_W-1:0];
   assign is_shift = alu_ctrl[3] & ~alu_ctrl[2] & ~(alu_ctrl[1] & alu_ctrl[0]);
   assign accept   = in_valid && in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
         SHIFT:   if (cnt_q == SHAMT_W'(1)) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs depend on state only
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Operand capture, iterative shifting and result hold
   always_ff @(posedge clk) begin
      if (rst) begin
         work_q <= '0;
         cnt_q  <= '0;
         ill_q  <= 1'b0;
         shk_q  <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shk_q <= alu_ctrl[1:0];
                  ill_q <= is_illegal(alu_ctrl);
                  if (is_shift) begin
                     work_q <= src_a;
                     cnt_q  <= shamt;
                  end else begin
                     work_q <= alu_fn(alu_ctrl, src_a, src_b);
                     cnt_q  <= '0;
                  end
               end
            end
            SHIFT: begin
               work_q <= shift1(shk_q, work_q);
               cnt_q  <= cnt_q - SHAMT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign result  = work_q;
   assign illegal = ill_q;

endmodule

// File: tb/tb_alu_exec_mc.sv
// tb_alu_exec_mc: directed-vector bench for alu_exec_mc.
module tb_alu_exec_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        illegal;

   int n_tests = 0;
   int n_fail  = 0;
   int hs      = 0;

   alu_exec_mc #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .illegal(illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (out_valid && out_ready) hs <= hs + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, scramble inputs after accept, wait for out_valid (bounded).
   task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input int lat_exp,
                         input logic [31:0] res_exp, input logic ill_exp);
      int lat;
      check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; alu_ctrl = c; src_a = a; src_b = b;
      tick();
      in_valid = 1'b0; alu_ctrl = 4'b0000; src_a = 32'hDEADBEEF; src_b = 32'h0BADF00D;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "/latency"}, 32'(lat), 32'(lat_exp));
      check({tag, "/result"}, result, res_exp);
      check({tag, "/illegal"}, 32'(illegal), 32'(ill_exp));
      if (out_ready) begin
         tick();
         check({tag, "/drop"}, 32'(out_valid), 32'd0);
         check({tag, "/ready"}, 32'(in_ready), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; alu_ctrl = 4'b0000;
      src_a = '0; src_b = '0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst/in_ready", 32'(in_ready), 32'd1);
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/result", result, 32'd0);
      check("rst/illegal", 32'(illegal), 32'd0);

      // Single-cycle ops
      run_op("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'd1, 1, 32'h00000000, 1'b0);
      run_op("sltu", 4'b0100, 32'd5, 32'hFFFFFFFF, 1, 32'd1, 1'b0);
      run_op("sltu_false", 4'b0100, 32'hFFFFFFFF, 32'd5, 1, 32'd0, 1'b0);
      run_op("jalr", 4'b0011, 32'h80000001, 32'h00000002, 1, 32'h80000002, 1'b0);
      run_op("lui", 4'b0001, 32'h11111111, 32'h12345000, 1, 32'h12345000, 1'b0);
      run_op("xor", 4'b0101, 32'h0000FF00, 32'h00000FF0, 1, 32'h0000F0F0, 1'b0);
      run_op("and", 4'b0111, 32'h0000FF00, 32'h00000FF0, 1, 32'h00000F00, 1'b0);

      // Shifts: latency = 1 + shamt
      run_op("sra31", 4'b1010, 32'h80000000, 32'd31, 32, 32'hFFFFFFFF, 1'b0);
      run_op("srl31", 4'b1001, 32'h80000000, 32'd31, 32, 32'h00000001, 1'b0);
      run_op("sll0", 4'b1000, 32'd1, 32'd0, 1, 32'd1, 1'b0);
      run_op("sll4", 4'b1000, 32'h00000003, 32'hFFFFFFE4, 5, 32'h00000030, 1'b0);
      run_op("sra_pos", 4'b1010, 32'h40000000, 32'd2, 3, 32'h10000000, 1'b0);

      // Backpressure hold
      out_ready = 1'b0;
      run_op("bp", 4'b0110, 32'h000000F0, 32'h0000000F, 1, 32'h000000FF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp/hold_valid", 32'(out_valid), 32'd1);
         check("bp/hold_result", result, 32'h000000FF);
         check("bp/hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp/release_ready", 32'(in_ready), 32'd1);
      check("bp/release_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of a shift
      in_valid = 1'b1; alu_ctrl = 4'b1000; src_a = 32'd1; src_b = 32'd20;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      check("mid/busy_valid", 32'(out_valid), 32'd0);
      check("mid/busy_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid/out_valid", 32'(out_valid), 32'd0);
      check("mid/result", result, 32'd0);
      check("mid/in_ready", 32'(in_ready), 32'd1);
      run_op("mid/add", 4'b0000, 32'd2, 32'd3, 1, 32'd5, 1'b0);

      // Illegal code and request ignored while in DONE
      out_ready = 1'b0;
      run_op("ill_1100", 4'b1100, 32'd3, 32'd4, 1, 32'd0, 1'b1);
      in_valid = 1'b1; alu_ctrl = 4'b0000; src_a = 32'd10; src_b = 32'd20;
      tick(); tick();
      in_valid = 1'b0;
      check("ign/result", result, 32'd0);
      check("ign/illegal", 32'(illegal), 32'd1);
      hs = 0;
      out_ready = 1'b1;
      repeat (6) tick();
      check("ign/handshakes", 32'(hs), 32'd1);
      check("ign/idle_valid", 32'(out_valid), 32'd0);
      run_op("ill_0010", 4'b0010, 32'd7, 32'd9, 1, 32'd0, 1'b1);
      run_op("ill_clear", 4'b0111, 32'hFFFFFFFF, 32'h0000AAAA, 1, 32'h0000AAAA, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/alu_exec_mc.md
Name: alu_exec_mc

Overview:
Multi-cycle execute unit that consumes the 4-bit alu_ctrl code produced by the NPC's ALU-control decoder and computes the result from two operands.
Sits in the EX stage between decode/operand-select and writeback, with valid/ready handshakes on both sides.
Logic ops, add and compare complete in one cycle. Shifts iterate one bit per cycle, so they need no barrel shifter.

Parameters:
XLEN, 32, operand/result width
SHAMT_W, 5, shift-amount width taken from src_b[SHAMT_W-1:0]

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept an operation
alu_ctrl  input  4  operation code (encoding below)
src_a  input  XLEN  operand A (rs1 / pc)
src_b  input  XLEN  operand B (rs2 / immediate)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  XLEN  computed result
illegal  output  1  qualified by out_valid; alu_ctrl was unassigned

Behaviour:
- Encoding:
  - 0000 add (a+b, wrap mod 2^XLEN)
  - 0001 pass b (lui)
  - 0011 jalr target ((a+b) & ~1)
  - 0100 unsigned less-than (result 1 or 0)
  - 0101 xor; 0110 or; 0111 and
  - 1000 sll; 1001 srl; 1010 sra
  - 0010 and 1011-1111: result 0, illegal=1
- FSM states: IDLE, SHIFT, DONE.
- Reset (rst high at an edge, any state, including mid-shift):
  - state becomes IDLE
  - out_valid=0, result=0, illegal=0
  - internal shift counter=0
  - in_ready=1 in the cycle after reset
- in_ready = (state==IDLE). It is combinational from state only and has no dependency on in_valid.
- Accept occurs when in_valid && in_ready at an edge. At accept, alu_ctrl, src_a and src_b are captured; later input changes are ignored.
- Non-shift op accepted in cycle N:
  - result registered at the edge ending N
  - out_valid=1 from cycle N+1; state goes to DONE
- Shift op with shamt = src_b[4:0]:
  - shamt==0: behaves as a non-shift op; result = src_a.
  - shamt>0: go to SHIFT with working reg = src_a and count = shamt.
  - Each SHIFT cycle shifts by 1 and decrements count:
    - sll: insert 0 at LSB
    - srl: insert 0 at MSB
    - sra: replicate bit XLEN-1
  - When count reaches 0, go to DONE.
  - out_valid=1 exactly at cycle N+1+shamt. Maximum latency is 32 cycles (shamt=31).
- DONE: result, illegal and out_valid are held stable while out_ready=0.
  - out_valid && out_ready at an edge: go to IDLE; out_valid drops next cycle.
  - No back-to-back accept in the same edge as the handoff. Throughput is at most one op per 2 cycles.
- out_valid is 0 in IDLE and SHIFT. result is don't-care when out_valid=0, but must not be X after reset.
- in_valid while busy is ignored; the request must be held by the producer.
- illegal is set only for unassigned codes. Shifts and valid ops clear it.

Test Plan:
1. Reset then add: a=0xFFFFFFFF, b=1, ctrl=0000, accept at cycle 0 -> out_valid at cycle 1, result=0x00000000, illegal=0.
2. Compare and jalr: ctrl=0100, a=5, b=0xFFFFFFFF -> result=1 (unsigned). Then ctrl=0011, a=0x80000001, b=0x00000002 -> result=0x80000002.
3. Shift latency: ctrl=1010, a=0x80000000, b=31 -> out_valid exactly at cycle 32, result=0xFFFFFFFF. Then ctrl=1001 with the same operands -> result=0x00000001. Then ctrl=1000, a=1, b=0 -> out_valid at cycle 1, result=1.
4. Backpressure: ctrl=0110, a=0xF0, b=0x0F, out_ready=0 for 5 cycles -> out_valid and result=0xFF held stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 the following cycle.
5. Reset mid-shift: ctrl=1000, a=1, b=20, assert rst at cycle 7 -> next cycle out_valid=0, result=0, in_ready=1. A subsequent add completes normally.
6. Illegal and ignored input: ctrl=1100, a=3, b=4 -> result=0, illegal=1. A second in_valid pulse while in DONE is not accepted; only one out_valid handshake occurs.
